// File: rtl/float_pkg.sv
// float_pkg: shared binary32 constants, FSM encoding and unpack/pack helpers for the float blocks
package float_pkg;
    localparam int EXP_BIAS = 127;
    localparam int EXP_W = 10;
    localparam int QUOT_BITS = 27;
    localparam logic [31:0] CANON_NAN = 32'hFFC00000;
    localparam logic [31:0] POS_INF = 32'h7F800000;
    typedef enum logic [3:0] {
        get_a, get_b, unpack, special_cases, normalise_a, normalise_b,
        divide_0, divide_1, divide_2, normalise_1, normalise_2, round, pack, put_z
    } state_t;
    typedef struct packed {
        logic s;
        logic signed [EXP_W-1:0] e;
        logic [23:0] m;
    } fp_t;
    // Unbiased exponent; the hidden bit is left clear until specials are resolved.
    function automatic fp_t fp_unpack(input logic [31:0] x);
        fp_t r;
        r.s = x[31];
        r.e = EXP_W'(x[30:23]) - EXP_W'(EXP_BIAS);
        r.m = {1'b0, x[22:0]};
        return r;
    endfunction
    // A denormal is recognised by sitting at the minimum exponent without its hidden bit.
    function automatic logic [31:0] fp_pack(input fp_t z);
        logic [7:0] ef;
        ef = ($signed(z.e) == -10'sd126 && !z.m[23]) ? 8'd0 : z.e[7:0] + 8'(EXP_BIAS);
        return ($signed(z.e) > 10'sd127) ? {z.s, POS_INF[30:0]} : {z.s, ef, z.m[22:0]};
    endfunction
endpackage

// File: rtl/float_divider_if.sv
// float_divider_if: stb/ack streaming bundle for two operands and one result
// slave: the arithmetic block (accepts a/b, drives z); master: the driver/arbiter side
interface float_divider_if;
    logic [31:0] input_a;
    logic        input_a_stb;
    logic        input_a_ack;
    logic [31:0] input_b;
    logic        input_b_stb;
    logic        input_b_ack;
    logic [31:0] output_z;
    logic        output_z_stb;
    logic        output_z_ack;
    modport slave (
        input  input_a, input_a_stb, input_b, input_b_stb, output_z_ack,
        output input_a_ack, input_b_ack, output_z, output_z_stb
    );
    modport master (
        output input_a, input_a_stb, input_b, input_b_stb, output_z_ack,
        input  input_a_ack, input_b_ack, output_z, output_z_stb
    );
endinterface

// File: rtl/float_div_mantissa.sv
// float_div_mantissa: restoring divider core, one quotient bit per cycle
// clk/rst: clock and sync active-high reset; start: load operands (24-bit mantissas)
// done: high during the final iteration cycle; quotient: low QUOT_BITS bits of (dividend<<26)/divisor
// rem_nz: final remainder is nonzero
module float_div_mantissa
    import float_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [23:0]          dividend,
    input  logic [23:0]          divisor,
    output logic                 done,
    output logic [QUOT_BITS-1:0] quotient,
    output logic                 rem_nz
);
    localparam int STEPS = QUOT_BITS + 24;
    logic [STEPS-1:0] num;
    logic [23:0] den, rem, diff;
    logic [24:0] trial;
    logic [5:0] count;
    logic busy, ge;
    assign trial = {rem, num[STEPS-1]};
    assign ge = trial >= {1'b0, den};
    // When ge holds the true difference is below den, so the low 24 bits are exact.
    assign diff = trial[23:0] - den;
    assign done = busy && count == 6'(STEPS - 1);
    assign rem_nz = rem != '0;
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
        end else if (start) begin
            num <= {1'b0, dividend, {(QUOT_BITS-1){1'b0}}};
            den <= divisor;
            rem <= '0;
            quotient <= '0;
            count <= '0;
            busy <= 1'b1;
        end else if (busy) begin
            num <= num << 1;
            rem <= ge ? diff : trial[23:0];
            quotient <= {quotient[QUOT_BITS-2:0], ge};
            count <= count + 6'd1;
            busy <= !done;
        end
    end
endmodule

// File: rtl/float_divider.sv
// float_divider: multi-cycle binary32 divider z = a / b with stb/ack streaming handshakes
// clk: clock; rst: sync active-high reset
// bus (slave): input_a/_stb/_ack dividend, input_b/_stb/_ack divisor, output_z/_stb/_ack quotient
module float_divider
    import float_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    float_divider_if.slave bus
);
    localparam logic signed [EXP_W-1:0] E_SPEC = 10'sd128;
    localparam logic signed [EXP_W-1:0] E_ZERO = -10'sd127;
    localparam logic signed [EXP_W-1:0] E_DEN = -10'sd126;
    state_t state, state_n;
    logic [31:0] a_raw, a_raw_n, b_raw, b_raw_n, z_out, z_out_n;
    fp_t a, a_n, b, b_n, z, z_n;
    logic guard, guard_n, round_bit, round_bit_n, sticky, sticky_n;
    logic a_ack, a_ack_n, b_ack, b_ack_n, z_stb, z_stb_n;
    logic start, done, rem_nz;
    logic [QUOT_BITS-1:0] quot;
    logic a_nan, a_inf, a_zero, b_nan, b_inf, b_zero, zs;
    float_div_mantissa core (
        .clk(clk), .rst(rst), .start(start), .dividend(a.m), .divisor(b.m),
        .done(done), .quotient(quot), .rem_nz(rem_nz)
    );
    assign bus.input_a_ack = a_ack;
    assign bus.input_b_ack = b_ack;
    assign bus.output_z_stb = z_stb;
    assign bus.output_z = z_out;
    assign a_nan = a.e == E_SPEC && a.m != '0;
    assign a_inf = a.e == E_SPEC && a.m == '0;
    assign a_zero = a.e == E_ZERO && a.m == '0;
    assign b_nan = b.e == E_SPEC && b.m != '0;
    assign b_inf = b.e == E_SPEC && b.m == '0;
    assign b_zero = b.e == E_ZERO && b.m == '0;
    assign zs = a.s ^ b.s;
    always_comb begin
        state_n = state;
        a_raw_n = a_raw;
        b_raw_n = b_raw;
        z_out_n = z_out;
        a_n = a;
        b_n = b;
        z_n = z;
        guard_n = guard;
        round_bit_n = round_bit;
        sticky_n = sticky;
        a_ack_n = a_ack;
        b_ack_n = b_ack;
        z_stb_n = z_stb;
        start = 1'b0;
        case (state)
            get_a: begin
                a_ack_n = 1'b1;
                if (a_ack && bus.input_a_stb) begin
                    a_raw_n = bus.input_a;
                    a_ack_n = 1'b0;
                    state_n = get_b;
                end
            end
            get_b: begin
                b_ack_n = 1'b1;
                if (b_ack && bus.input_b_stb) begin
                    b_raw_n = bus.input_b;
                    b_ack_n = 1'b0;
                    state_n = unpack;
                end
            end
            unpack: begin
                a_n = fp_unpack(a_raw);
                b_n = fp_unpack(b_raw);
                state_n = special_cases;
            end
            special_cases: begin
                if (a_nan || b_nan || a_inf || b_inf || a_zero || b_zero) begin
                    z_out_n = (a_nan || b_nan || (a_inf && b_inf) || (a_zero && b_zero)) ? CANON_NAN :
                              (a_inf || b_zero) ? {zs, POS_INF[30:0]} : {zs, 31'd0};
                    state_n = put_z;
                end else begin
                    a_n.e = a.e == E_ZERO ? E_DEN : a.e;
                    a_n.m[23] = a.e != E_ZERO;
                    b_n.e = b.e == E_ZERO ? E_DEN : b.e;
                    b_n.m[23] = b.e != E_ZERO;
                    state_n = normalise_a;
                end
            end
            normalise_a: begin
                if (a.m[23]) state_n = normalise_b;
                else begin
                    a_n.m = a.m << 1;
                    a_n.e = a.e - 10'sd1;
                end
            end
            normalise_b: begin
                if (b.m[23]) state_n = divide_0;
                else begin
                    b_n.m = b.m << 1;
                    b_n.e = b.e - 10'sd1;
                end
            end
            divide_0: begin
                z_n.s = zs;
                z_n.e = a.e - b.e;
                start = 1'b1;
                state_n = divide_1;
            end
            divide_1: state_n = done ? divide_2 : divide_1;
            divide_2: begin
                z_n.m = quot[26:3];
                guard_n = quot[2];
                round_bit_n = quot[1];
                sticky_n = quot[0] | rem_nz;
                state_n = normalise_1;
            end
            normalise_1: begin
                // Mantissa ratio below 1 leaves the leading one at bit 22; one shift restores it.
                if (!z.m[23]) begin
                    z_n.m = {z.m[22:0], guard};
                    guard_n = round_bit;
                    round_bit_n = 1'b0;
                    z_n.e = z.e - 10'sd1;
                end
                state_n = normalise_2;
            end
            normalise_2: begin
                if ($signed(z.e) < E_DEN) begin
                    z_n.m = z.m >> 1;
                    guard_n = z.m[0];
                    round_bit_n = guard;
                    sticky_n = sticky | round_bit;
                    z_n.e = z.e + 10'sd1;
                end else state_n = round;
            end
            round: begin
                if (guard && (round_bit || sticky || z.m[0])) begin
                    z_n.m = z.m + 24'd1;
                    if (&z.m) z_n.e = z.e + 10'sd1;
                end
                state_n = pack;
            end
            pack: begin
                z_out_n = fp_pack(z);
                state_n = put_z;
            end
            put_z: begin
                z_stb_n = 1'b1;
                if (z_stb && bus.output_z_ack) begin
                    z_stb_n = 1'b0;
                    state_n = get_a;
                end
            end
            default: state_n = get_a;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= get_a;
            a_ack <= 1'b0;
            b_ack <= 1'b0;
            z_stb <= 1'b0;
        end else begin
            state <= state_n;
            a_ack <= a_ack_n;
            b_ack <= b_ack_n;
            z_stb <= z_stb_n;
            a_raw <= a_raw_n;
            b_raw <= b_raw_n;
            z_out <= z_out_n;
            a <= a_n;
            b <= b_n;
            z <= z_n;
            guard <= guard_n;
            round_bit <= round_bit_n;
            sticky <= sticky_n;
        end
    end
endmodule

// File: tb/tb_float_divider.sv
// tb_float_divider: self-checking bench for float_divider against an exact-arithmetic reference
module tb_float_divider;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;
    localparam int BUDGET = 2000;
    float_divider_if bus();
    float_divider dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    // Reference: exact integer quotient with a wide scale, then IEEE round-to-nearest-even.
    function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        logic s, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, st, up;
        logic [127:0] ma, mb, num, q, keep, dropped, half;
        int ea, eb, p, e, lsb, sh;
        s = a[31] ^ b[31];
        a_nan = a[30:23] == 8'hFF && a[22:0] != 0;
        b_nan = b[30:23] == 8'hFF && b[22:0] != 0;
        a_inf = a[30:23] == 8'hFF && a[22:0] == 0;
        b_inf = b[30:23] == 8'hFF && b[22:0] == 0;
        a_zero = a[30:0] == 0;
        b_zero = b[30:0] == 0;
        if (a_nan || b_nan || (a_inf && b_inf)) return 32'hFFC00000;
        if (a_inf) return {s, 8'hFF, 23'd0};
        if (b_inf) return {s, 31'd0};
        if (b_zero) return a_zero ? 32'hFFC00000 : {s, 8'hFF, 23'd0};
        if (a_zero) return {s, 31'd0};
        ma = 128'({a[30:23] != 0, a[22:0]});
        mb = 128'({b[30:23] != 0, b[22:0]});
        ea = (a[30:23] == 0 ? -126 : int'(a[30:23]) - 127) - 23;
        eb = (b[30:23] == 0 ? -126 : int'(b[30:23]) - 127) - 23;
        num = ma << 60;
        q = num / mb;
        st = (num % mb) != 0;
        p = 127;
        while (p > 0 && !q[p]) p--;
        e = p + ea - eb - 60;
        lsb = e < -126 ? -149 : e - 23;
        sh = lsb - (ea - eb - 60);
        if (sh > 100) return {s, 31'd0};
        keep = q >> sh;
        dropped = q - (keep << sh);
        half = 128'd1 << (sh - 1);
        up = dropped > half || (dropped == half && (st || keep[0]));
        keep = keep + 128'(up);
        if (e < -126) return {s, keep[30:0]};
        if (keep[24]) begin
            keep = keep >> 1;
            e++;
        end
        if (e > 127) return {s, 8'hFF, 23'd0};
        return {s, 8'(e + 127), keep[22:0]};
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [31:0] r;
        int k;
        r = $urandom;
        k = $urandom_range(0, 9);
        case (k)
            0: r[30:23] = 8'd0;
            1: begin
                r[30:23] = 8'hFF;
                if ($urandom_range(0, 1) == 0) r[22:0] = 23'd0;
            end
            2: r[30:23] = 8'($urandom_range(240, 254));
            3: r[30:23] = 8'($urandom_range(1, 20));
            4: r[30:0] = 31'd0;
            default: r[30:23] = 8'($urandom_range(100, 154));
        endcase
        return r;
    endfunction

    task automatic send_a(input logic [31:0] x);
        int n = 0;
        bus.input_a = x;
        bus.input_a_stb = 1'b1;
        @(negedge clk);
        while (!bus.input_a_ack && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 bus.input_a_stb = 1'b0;
    endtask

    task automatic send_b(input logic [31:0] x);
        int n = 0;
        bus.input_b = x;
        bus.input_b_stb = 1'b1;
        @(negedge clk);
        while (!bus.input_b_ack && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 bus.input_b_stb = 1'b0;
    endtask

    // A result that never arrives comes back as X so the caller's comparison fails.
    task automatic recv_z(output logic [31:0] z);
        int n = 0;
        bus.output_z_ack = 1'b1;
        @(negedge clk);
        while (!bus.output_z_stb && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        z = bus.output_z_stb ? bus.output_z : 32'hxxxxxxxx;
        @(posedge clk);
        #1 bus.output_z_ack = 1'b0;
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, output logic [31:0] z);
        send_a(a);
        send_b(b);
        recv_z(z);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.input_a_ack !== 1'b0) begin failures++; $display("FAIL reset_a_ack got=%b want=0", bus.input_a_ack); end
        checks++;
        if (bus.input_b_ack !== 1'b0) begin failures++; $display("FAIL reset_b_ack got=%b want=0", bus.input_b_ack); end
        checks++;
        if (bus.output_z_stb !== 1'b0) begin failures++; $display("FAIL reset_z_stb got=%b want=0", bus.output_z_stb); end
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bus.input_a_ack !== 1'b1) begin failures++; $display("FAIL reset_a_ack_rise got=%b want=1", bus.input_a_ack); end
        checks++;
        if (bus.input_b_ack !== 1'b0) begin failures++; $display("FAIL reset_b_idle got=%b want=0", bus.input_b_ack); end
    endtask

    task automatic test_exact();
        logic [31:0] va[3] = '{32'h40C00000, 32'hC1200000, 32'h3F800000};
        logic [31:0] vb[3] = '{32'h40000000, 32'h40A00000, 32'h3F800000};
        logic [31:0] ve[3] = '{32'h40400000, 32'hC0000000, 32'h3F800000};
        logic [31:0] z;
        for (int i = 0; i < 3; i++) begin
            run_op(va[i], vb[i], z);
            checks++;
            if (z !== ve[i]) begin failures++; $display("FAIL exact %h/%h got=%h want=%h", va[i], vb[i], z, ve[i]); end
        end
    endtask

    task automatic test_rounding();
        logic [31:0] z;
        run_op(32'h3F800000, 32'h40400000, z);
        checks++;
        if (z !== 32'h3EAAAAAB) begin failures++; $display("FAIL round_1_3 got=%h want=3eaaaaab", z); end
        run_op(32'hC0000000, 32'h40400000, z);
        checks++;
        if (z !== 32'hBF2AAAAB) begin failures++; $display("FAIL round_m2_3 got=%h want=bf2aaaab", z); end
    endtask

    task automatic test_specials();
        logic [31:0] va[6] = '{32'h3F800000, 32'h00000000, 32'hBF800000, 32'h7FC00001, 32'h7F800000, 32'hFF800000};
        logic [31:0] vb[6] = '{32'h00000000, 32'h00000000, 32'h7F800000, 32'h3F800000, 32'h7F800000, 32'h40000000};
        logic [31:0] ve[6] = '{32'h7F800000, 32'hFFC00000, 32'h80000000, 32'hFFC00000, 32'hFFC00000, 32'hFF800000};
        logic [31:0] z;
        for (int i = 0; i < 6; i++) begin
            run_op(va[i], vb[i], z);
            checks++;
            if (z !== ve[i]) begin failures++; $display("FAIL special %h/%h got=%h want=%h", va[i], vb[i], z, ve[i]); end
        end
    endtask

    task automatic test_denormal_overflow();
        logic [31:0] va[4] = '{32'h00800000, 32'h00000003, 32'h7F7FFFFF, 32'h00400000};
        logic [31:0] vb[4] = '{32'h40000000, 32'h40000000, 32'h3F000000, 32'h3F000000};
        logic [31:0] ve[4] = '{32'h00400000, 32'h00000002, 32'h7F800000, 32'h00800000};
        logic [31:0] z;
        for (int i = 0; i < 4; i++) begin
            run_op(va[i], vb[i], z);
            checks++;
            if (z !== ve[i]) begin failures++; $display("FAIL denorm_ovf %h/%h got=%h want=%h", va[i], vb[i], z, ve[i]); end
        end
    endtask

    task automatic test_b_delay();
        logic [31:0] z;
        send_a(32'h40C00000);
        bus.input_b = 32'h40000000;
        @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (bus.input_b_ack !== 1'b1) begin failures++; $display("FAIL b_delay_ack cycle=%0d got=%b want=1", i, bus.input_b_ack); end
        end
        send_b(32'h40000000);
        checks++;
        if (bus.input_b_ack !== 1'b0) begin failures++; $display("FAIL b_ack_drop got=%b want=0", bus.input_b_ack); end
        recv_z(z);
        checks++;
        if (z !== 32'h40400000) begin failures++; $display("FAIL b_delay_result got=%h want=40400000", z); end
    endtask

    task automatic test_z_hold();
        logic [31:0] z0;
        int n = 0;
        send_a(32'h3F800000);
        send_b(32'h40400000);
        bus.output_z_ack = 1'b0;
        @(negedge clk);
        while (!bus.output_z_stb && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        z0 = bus.output_z;
        checks++;
        if (z0 !== 32'h3EAAAAAB) begin failures++; $display("FAIL hold_value got=%h want=3eaaaaab", z0); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (bus.output_z_stb !== 1'b1 || bus.output_z !== z0) begin
                failures++;
                $display("FAIL hold_stable cycle=%0d got stb=%b z=%h want stb=1 z=%h", i, bus.output_z_stb, bus.output_z, z0);
            end
        end
        bus.output_z_ack = 1'b1;
        @(posedge clk);
        #1 bus.output_z_ack = 1'b0;
        checks++;
        if (bus.output_z_stb !== 1'b0) begin failures++; $display("FAIL hold_stb_drop got=%b want=0", bus.output_z_stb); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b, z, e;
        for (int i = 0; i < 10; i++) begin
            a = {$urandom_range(0, 1) == 1, 8'($urandom_range(110, 145)), 23'($urandom)};
            b = {$urandom_range(0, 1) == 1, 8'($urandom_range(110, 145)), 23'($urandom)};
            e = ref_div(a, b);
            run_op(a, b, z);
            checks++;
            if (z !== e) begin failures++; $display("FAIL b2b %h/%h got=%h want=%h", a, b, z, e); end
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b, z, e;
        for (int i = 0; i < 60; i++) begin
            a = rand_fp();
            b = rand_fp();
            e = ref_div(a, b);
            run_op(a, b, z);
            checks++;
            if (z !== e) begin failures++; $display("FAIL random %h/%h got=%h want=%h", a, b, z, e); end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] z;
        logic seen = 1'b0;
        send_a(32'h3F800000);
        send_b(32'h40400000);
        repeat (20) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.input_a_ack !== 1'b0 || bus.input_b_ack !== 1'b0 || bus.output_z_stb !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_outputs got a=%b b=%b z=%b want 0 0 0", bus.input_a_ack, bus.input_b_ack, bus.output_z_stb);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bus.input_a_ack !== 1'b1) begin failures++; $display("FAIL mid_reset_get_a got=%b want=1", bus.input_a_ack); end
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (bus.output_z_stb === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin failures++; $display("FAIL mid_reset_no_result got=%b want=0", seen); end
        run_op(32'h40C00000, 32'h40000000, z);
        checks++;
        if (z !== 32'h40400000) begin failures++; $display("FAIL mid_reset_next got=%h want=40400000", z); end
    endtask

    initial begin
        bus.input_a = '0;
        bus.input_a_stb = 1'b0;
        bus.input_b = '0;
        bus.input_b_stb = 1'b0;
        bus.output_z_ack = 1'b0;
        test_reset();
        test_exact();
        test_rounding();
        test_specials();
        test_denormal_overflow();
        test_b_delay();
        test_z_hold();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
